// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : Bus 2 (A2/D2/C2) between the L1 cache and the backing-store
//            memory controller. D2 and C2 are shared lines; each side
//            presents a value plus an output enable, and the shared wire
//            carries the enabled driver's value or floats to 'z.
// Signals  : A2_WIRE       line address, driven by the cache only
//            D2_WIRE       data beats, [7:0] lower-address byte
//            C2_WIRE       command / response code
//            cache_*       cache-side drive value and enable
//            mem_*         controller-side drive value and enable
//            mem_accesses  count of commands accepted by the controller
// Modports : master (cache side), slave (memory controller side)
// Revision : 1.0  initial release
// ============================================================================
interface mem_ctrl_if #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA_BUS_SIZE  = 16,
  parameter int CTR2_BUS_SIZE  = 2
);
  logic [ADDR2_BUS_SIZE-1:0] A2_WIRE;
  wire  [DATA_BUS_SIZE-1:0]  D2_WIRE;
  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE;

  logic                      cache_d2_oe;
  logic [DATA_BUS_SIZE-1:0]  cache_d2;
  logic                      cache_c2_oe;
  logic [CTR2_BUS_SIZE-1:0]  cache_c2;

  logic                      mem_d2_oe;
  logic [DATA_BUS_SIZE-1:0]  mem_d2;
  logic                      mem_c2_oe;
  logic [CTR2_BUS_SIZE-1:0]  mem_c2;

  logic [31:0]               mem_accesses;

  // The bus protocol guarantees the two sides never enable together.
  assign D2_WIRE = mem_d2_oe   ? mem_d2   :
                   cache_d2_oe ? cache_d2 : {DATA_BUS_SIZE{1'bz}};
  assign C2_WIRE = mem_c2_oe   ? mem_c2   :
                   cache_c2_oe ? cache_c2 : {CTR2_BUS_SIZE{1'bz}};

  modport master (
    output A2_WIRE, cache_d2_oe, cache_d2, cache_c2_oe, cache_c2,
    input  D2_WIRE, C2_WIRE, mem_accesses
  );

  modport slave (
    input  A2_WIRE, D2_WIRE, C2_WIRE,
    output mem_d2_oe, mem_d2, mem_c2_oe, mem_c2, mem_accesses
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Backing-store memory controller below the L1 cache. Serves
//            line-granular READ_LINE / WRITE_LINE commands on bus 2 with a
//            fixed access latency of MEM_DELAY cycles from the command edge
//            to the first response edge. A line moves as CACHE_LINE_SIZE/2
//            little-endian 16-bit beats on D2.
// Ports    : CLK    system clock, all activity on posedge
//            RESET  asynchronous active-low reset
//            bus    mem_ctrl_if.slave (A2 in, D2/C2 shared, mem_accesses out)
// Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA_BUS_SIZE   = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int MEM_DELAY       = 100
) (
  input  wire logic    CLK,
  input  wire logic    RESET,
  mem_ctrl_if.slave    bus
);

  localparam int c_BEATS     = CACHE_LINE_SIZE / 2;
  localparam int c_LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int c_CNT_W     = $clog2(MEM_DELAY + 1);
  localparam int c_BEAT_W    = $clog2(c_BEATS);

  localparam logic [c_CNT_W-1:0]       c_CNT_LAST  = c_CNT_W'(MEM_DELAY - 1);
  localparam logic [c_BEAT_W-1:0]      c_BEAT_LAST = c_BEAT_W'(c_BEATS - 1);
  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV_WR = 3'd1,
    WAIT    = 3'd2,
    RESP_WR = 3'd3,
    SEND_RD = 3'd4
  } state_t;

  state_t                     r_state;
  logic [c_CNT_W-1:0]         r_cnt;
  logic [c_BEAT_W-1:0]        r_beat;
  logic [ADDR2_BUS_SIZE-1:0]  r_addr;
  logic                       r_is_write;
  logic [c_LINE_BITS-1:0]     r_buf;
  logic [DATA_BUS_SIZE-1:0]   r_d2;
  logic                       r_d2_oe;
  logic                       r_c2_oe;
  logic [31:0]                r_accesses;

  logic [c_LINE_BITS-1:0]     r_mem [2**ADDR2_BUS_SIZE];

  logic                       w_commit;

  // The write buffer lands in the array as a single whole-line update on the
  // last WAIT cycle, so a reset before that point leaves the line untouched.
  assign w_commit = (r_state == WAIT) && r_is_write && (r_cnt == c_CNT_LAST);

  always_ff @(posedge CLK) begin
    if (w_commit) begin
      r_mem[r_addr] <= r_buf;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_is_write <= 1'b0;
      r_buf      <= '0;
      r_d2       <= '0;
      r_d2_oe    <= 1'b0;
      r_c2_oe    <= 1'b0;
      r_accesses <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Anything other than the two command codes (NOP, RESPONSE, or a
          // floating bus) is treated as no command.
          if (bus.C2_WIRE == c_C2_READ_LINE) begin
            r_addr     <= bus.A2_WIRE;
            r_cnt      <= c_CNT_W'(1);
            r_beat     <= '0;
            r_is_write <= 1'b0;
            r_accesses <= r_accesses + 32'd1;
            r_state    <= WAIT;
          end else if (bus.C2_WIRE == c_C2_WRITE_LINE) begin
            // Beat 0 travels with the command itself.
            r_addr     <= bus.A2_WIRE;
            r_buf[DATA_BUS_SIZE-1:0] <= bus.D2_WIRE;
            r_cnt      <= c_CNT_W'(1);
            r_beat     <= c_BEAT_W'(1);
            r_is_write <= 1'b1;
            r_accesses <= r_accesses + 32'd1;
            r_state    <= RECV_WR;
          end
        end

        RECV_WR: begin
          r_buf[int'(r_beat)*DATA_BUS_SIZE +: DATA_BUS_SIZE] <= bus.D2_WIRE;
          r_cnt <= r_cnt + 1'b1;
          if (r_beat == c_BEAT_LAST) begin
            r_beat  <= '0;
            r_state <= WAIT;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end

        WAIT: begin
          // The counter already carries the cycles spent receiving write
          // beats, so both command kinds leave WAIT on the same edge and the
          // first response is visible exactly MEM_DELAY edges after the
          // command edge.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_c2_oe <= 1'b1;
            if (r_is_write) begin
              r_state <= RESP_WR;
            end else begin
              r_buf   <= r_mem[r_addr];
              r_d2    <= r_mem[r_addr][DATA_BUS_SIZE-1:0];
              r_d2_oe <= 1'b1;
              r_beat  <= '0;
              r_state <= SEND_RD;
            end
          end
        end

        RESP_WR: begin
          r_c2_oe <= 1'b0;
          r_state <= IDLE;
        end

        SEND_RD: begin
          if (r_beat == c_BEAT_LAST) begin
            r_c2_oe <= 1'b0;
            r_d2_oe <= 1'b0;
            r_beat  <= '0;
            r_state <= IDLE;
          end else begin
            r_d2   <= r_buf[(int'(r_beat) + 1)*DATA_BUS_SIZE +: DATA_BUS_SIZE];
            r_beat <= r_beat + 1'b1;
          end
        end

        default: begin
          r_c2_oe <= 1'b0;
          r_d2_oe <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_c2       = c_C2_RESPONSE;
  assign bus.mem_c2_oe    = r_c2_oe;
  assign bus.mem_d2       = r_d2;
  assign bus.mem_d2_oe    = r_d2_oe;
  assign bus.mem_accesses = r_accesses;

endmodule
`default_nettype wire
